// File: rtl/b2b_board_link_framer_if.sv
// b2b_board_link_framer_if: FIFO-side and link-side stream signals of the framer
interface b2b_board_link_framer_if #(parameter int DATA_WIDTH = 65);
  logic [DATA_WIDTH-1:0] fifo_read_data;
  logic fifo_empty;
  logic fifo_read_enable;
  logic [DATA_WIDTH-1:0] out_data;
  logic out_valid;
  logic out_last;
  logic out_ready;
  modport master (
    input fifo_read_data, fifo_empty, out_ready,
    output fifo_read_enable, out_data, out_valid, out_last
  );
  modport slave (
    output fifo_read_data, fifo_empty, out_ready,
    input fifo_read_enable, out_data, out_valid, out_last
  );
endinterface

// File: rtl/b2b_board_link_framer.sv
// b2b_board_link_framer: drains a board FIFO, checks header/data/footer framing and streams events to the link
module b2b_board_link_framer #(
  parameter int DATA_WIDTH = 65,
  parameter int BUF_DEPTH = 4,
  parameter int MAX_EVENT_WORDS = 4095,
  parameter int CNT_WIDTH = 32
) (
  input logic clock,
  input logic reset,
  b2b_board_link_framer_if.master link,
  output logic [CNT_WIDTH-1:0] event_count,
  output logic [11:0] last_event_words,
  output logic [CNT_WIDTH-1:0] framing_error_count,
  output logic overflow_flag
);
  localparam int AW = $clog2(BUF_DEPTH);
  typedef enum logic {IDLE, BODY} state_t;
  state_t state, state_nx;
  logic inflight;
  logic [AW:0] occ;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] buf_data [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] buf_last;
  logic [11:0] word_cnt;
  logic is_meta, push, push_last, drop_err, drop_ovf, done, pop;
  // Reads are budgeted against words already buffered plus the one still in flight, so a push can never overflow
  assign link.fifo_read_enable = !reset && !link.fifo_empty &&
                                 ((occ + (AW+1)'(inflight)) < (AW+1)'(BUF_DEPTH));
  assign link.out_valid = occ != '0;
  assign link.out_data = buf_data[rd_ptr];
  assign link.out_last = link.out_valid && buf_last[rd_ptr];
  assign pop = link.out_valid && link.out_ready;
  assign is_meta = link.fifo_read_data[DATA_WIDTH-1];
  // Classify the arriving word; a metadata word seen in BODY always closes the event
  always_comb begin
    state_nx = state;
    push = 1'b0;
    push_last = 1'b0;
    drop_err = 1'b0;
    drop_ovf = 1'b0;
    done = 1'b0;
    if (inflight) begin
      if (state == IDLE) begin
        push = is_meta;
        drop_err = !is_meta;
        state_nx = is_meta ? BODY : IDLE;
      end else if (is_meta) begin
        push = 1'b1;
        push_last = 1'b1;
        done = 1'b1;
        state_nx = IDLE;
      end else begin
        push = word_cnt < 12'(MAX_EVENT_WORDS);
        drop_ovf = !push;
      end
    end
  end
  // Framing state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // Read tracking and circular skid buffer; clearing inflight on reset discards any returning word
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      inflight <= 1'b0;
      occ <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      buf_last <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_data[i] <= '0;
    end else begin
      inflight <= link.fifo_read_enable;
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
      if (push) begin
        buf_data[wr_ptr] <= link.fifo_read_data;
        buf_last[wr_ptr] <= push_last;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
    end
  // Statistics follow the arrival cycle; the word counter is held at zero while waiting for a header
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      word_cnt <= '0;
      event_count <= '0;
      last_event_words <= '0;
      framing_error_count <= '0;
      overflow_flag <= 1'b0;
    end else begin
      word_cnt <= (state == IDLE) ? '0 : word_cnt + 12'(push && !push_last);
      event_count <= event_count + CNT_WIDTH'(done);
      framing_error_count <= framing_error_count + CNT_WIDTH'(drop_err);
      overflow_flag <= overflow_flag | drop_ovf;
      if (done) last_event_words <= word_cnt;
    end
endmodule
